uart_cfg: RTL and testbench

Next-generation UART transceiver with a compile-time frame format (5–8 data bits, none/odd/even parity, 1 or 2 stop bits).
- Receiver uses 16x oversampling with 3-sample majority voting.
- Receiver reports framing, parity, overrun and break conditions.
- Sits between the board serial pins and the byte-level host logic (touch/command interfaces), using the same rx_avail/rx_ack and tx_wr/tx_busy handshake.

---
 rtl/uart_cfg.sv | 322 ++++++++++++++++++++++++++++++++
 tb/tb_uart_cfg.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cfg.sv
// UART transceiver with a compile-time frame format (5..8 data bits, optional parity, 1/2 stop bits).
// RX: 2-flop synchroniser, 16x oversampling, 3-sample majority; TX: tick-paced shift-out.
module uart_cfg #(
  parameter int freq_hz   = 50000000,
  parameter int baud      = 115200,
  parameter int data_bits = 8,
  parameter int parity    = 0,
  parameter int stop_bits = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic [7:0] rx_data,
  output logic       rx_avail,
  output logic       rx_error,
  output logic       rx_parity_err,
  output logic       rx_overrun,
  output logic       rx_break,
  input  logic       rx_ack,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_busy
);

  localparam int DIV = freq_hz / (baud * 16);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_M1    = CW'(DIV - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(data_bits - 1);
  localparam logic          STOP_LAST = 1'(stop_bits - 1);
  localparam logic [7:0]    DATA_MASK = 8'((1 << data_bits) - 1);
  localparam bit            HAS_PAR   = (parity != 0);
  localparam bit            PAR_ODD   = (parity == 1);

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
  } rx_state_e;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_e;

  // ---------------- tick generator and input synchroniser ----------------
  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;
  logic [1:0]    sync_q, sync_d;
  logic          rxs;

  always_comb begin
    tick       = (tick_cnt_q == '0);
    tick_cnt_d = tick ? DIV_M1 : tick_cnt_q - CW'(1);
    sync_d     = {sync_q[0], uart_rxd};
    rxs        = sync_q[1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q <= '0;
      sync_q     <= 2'b11;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      sync_q     <= sync_d;
    end
  end

  // ---------------- receiver ----------------
  // Host handshake: rx_avail stays high until rx_ack; tx_wr is taken only while tx_busy is low.
  rx_state_e  rx_state_q, rx_state_d;
  logic [3:0] rx_phase_q, rx_phase_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic       rx_s7_q, rx_s7_d, rx_s8_q, rx_s8_d;
  logic       rx_par_q, rx_par_d, rx_ones_q, rx_ones_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_avail_q, rx_avail_d, rx_error_q, rx_error_d;
  logic       rx_perr_q, rx_perr_d, rx_ovr_q, rx_ovr_d, rx_brk_q, rx_brk_d;
  logic       rx_maj, rx_exp_par, rx_mismatch, rx_done_ok, rx_done_err;

  assign rx_maj      = (rx_s7_q & rx_s8_q) | (rx_s7_q & rxs) | (rx_s8_q & rxs);
  assign rx_exp_par  = PAR_ODD ? ~(^rx_shift_q) : (^rx_shift_q);
  assign rx_mismatch = HAS_PAR & (rx_par_q ^ rx_exp_par);

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_phase_d  = rx_phase_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_s7_d     = rx_s7_q;
    rx_s8_d     = rx_s8_q;
    rx_par_d    = rx_par_q;
    rx_ones_d   = rx_ones_q;
    rx_data_d   = rx_data_q;
    rx_avail_d  = rx_avail_q;
    rx_error_d  = rx_error_q;
    rx_perr_d   = rx_perr_q;
    rx_ovr_d    = rx_ovr_q;
    rx_brk_d    = rx_brk_q;
    rx_done_ok  = 1'b0;
    rx_done_err = 1'b0;
    if (rx_ack) begin
      rx_avail_d = 1'b0;
      rx_error_d = 1'b0;
      rx_perr_d  = 1'b0;
      rx_ovr_d   = 1'b0;
      rx_brk_d   = 1'b0;
    end
    if (tick) begin
      case (rx_state_q)
        RX_IDLE: begin
          if (!rxs) begin
            rx_state_d = RX_START;
            rx_phase_d = '0;
          end
        end
        RX_WAIT_HIGH: begin
          if (rxs) rx_state_d = RX_IDLE;
        end
        default: begin
          rx_phase_d = rx_phase_q + 4'd1;
          if (rx_phase_q == 4'd7) rx_s7_d = rxs;
          if (rx_phase_q == 4'd8) rx_s8_d = rxs;
          if (rx_phase_q == 4'd9) begin
            case (rx_state_q)
              RX_START: begin
                if (rx_maj) begin
                  rx_state_d = RX_IDLE;
                end else begin
                  rx_shift_d = '0;
                  rx_ones_d  = 1'b0;
                  rx_bit_d   = '0;
                end
              end
              RX_DATA: begin
                rx_shift_d[rx_bit_q] = rx_maj;
                rx_ones_d            = rx_ones_q | rx_maj;
              end
              RX_PARITY: begin
                rx_par_d  = rx_maj;
                rx_ones_d = rx_ones_q | rx_maj;
              end
              RX_STOP: begin
                if (rx_maj) rx_done_ok = 1'b1;
                else        rx_done_err = 1'b1;
              end
              default: ;
            endcase
          end
          if (rx_phase_q == 4'd15) begin
            case (rx_state_q)
              RX_START:  rx_state_d = RX_DATA;
              RX_DATA: begin
                if (rx_bit_q == LAST_BIT) rx_state_d = HAS_PAR ? RX_PARITY : RX_STOP;
                else                      rx_bit_d   = rx_bit_q + 3'd1;
              end
              RX_PARITY: rx_state_d = RX_STOP;
              default: ;
            endcase
          end
        end
      endcase
    end
    // A completing frame overrides a simultaneous rx_ack.
    if (rx_done_ok) begin
      rx_state_d = RX_IDLE;
      rx_data_d  = rx_shift_q;
      rx_avail_d = 1'b1;
      rx_perr_d  = rx_mismatch;
      rx_error_d = 1'b0;
      rx_brk_d   = 1'b0;
      rx_ovr_d   = rx_avail_q;
    end
    if (rx_done_err) begin
      rx_state_d = RX_WAIT_HIGH;
      rx_error_d = 1'b1;
      if (!rx_ones_q) rx_brk_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      rx_phase_q <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_s7_q    <= 1'b1;
      rx_s8_q    <= 1'b1;
      rx_par_q   <= 1'b0;
      rx_ones_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_avail_q <= 1'b0;
      rx_error_q <= 1'b0;
      rx_perr_q  <= 1'b0;
      rx_ovr_q   <= 1'b0;
      rx_brk_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_phase_q <= rx_phase_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_s7_q    <= rx_s7_d;
      rx_s8_q    <= rx_s8_d;
      rx_par_q   <= rx_par_d;
      rx_ones_q  <= rx_ones_d;
      rx_data_q  <= rx_data_d;
      rx_avail_q <= rx_avail_d;
      rx_error_q <= rx_error_d;
      rx_perr_q  <= rx_perr_d;
      rx_ovr_q   <= rx_ovr_d;
      rx_brk_q   <= rx_brk_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_avail      = rx_avail_q;
  assign rx_error      = rx_error_q;
  assign rx_parity_err = rx_perr_q;
  assign rx_overrun    = rx_ovr_q;
  assign rx_break      = rx_brk_q;

  // ---------------- transmitter ----------------
  tx_state_e  tx_state_q, tx_state_d;
  logic [3:0] tx_phase_q, tx_phase_d;
  logic [2:0] tx_bit_q, tx_bit_d, tx_nbit;
  logic       tx_stop_q, tx_stop_d;
  logic       tx_armed_q, tx_armed_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       tx_txd_q, tx_txd_d;
  logic       tx_par;

  assign tx_par = PAR_ODD ? ~(^tx_shift_q) : (^tx_shift_q);

  always_comb begin
    tx_state_d = tx_state_q;
    tx_phase_d = tx_phase_q;
    tx_bit_d   = tx_bit_q;
    tx_stop_d  = tx_stop_q;
    tx_armed_d = tx_armed_q;
    tx_shift_d = tx_shift_q;
    tx_txd_d   = tx_txd_q;
    tx_nbit    = tx_bit_q + 3'd1;
    case (tx_state_q)
      TX_IDLE: begin
        tx_txd_d = 1'b1;
        if (tx_wr) begin
          tx_shift_d = tx_data & DATA_MASK;
          tx_armed_d = 1'b0;
          tx_state_d = TX_START;
        end
      end
      default: begin
        if (tick) begin
          // The start bit waits for the first tick after acceptance, then every bit spans 16 ticks.
          if (tx_state_q == TX_START && !tx_armed_q) begin
            tx_armed_d = 1'b1;
            tx_txd_d   = 1'b0;
            tx_phase_d = '0;
          end else if (tx_phase_q != 4'd15) begin
            tx_phase_d = tx_phase_q + 4'd1;
          end else begin
            tx_phase_d = '0;
            case (tx_state_q)
              TX_START: begin
                tx_state_d = TX_DATA;
                tx_bit_d   = '0;
                tx_txd_d   = tx_shift_q[0];
              end
              TX_DATA: begin
                if (tx_bit_q == LAST_BIT) begin
                  if (HAS_PAR) begin
                    tx_state_d = TX_PARITY;
                    tx_txd_d   = tx_par;
                  end else begin
                    tx_state_d = TX_STOP;
                    tx_txd_d   = 1'b1;
                    tx_stop_d  = 1'b0;
                  end
                end else begin
                  tx_bit_d = tx_nbit;
                  tx_txd_d = tx_shift_q[tx_nbit];
                end
              end
              TX_PARITY: begin
                tx_state_d = TX_STOP;
                tx_txd_d   = 1'b1;
                tx_stop_d  = 1'b0;
              end
              TX_STOP: begin
                if (tx_stop_q == STOP_LAST) tx_state_d = TX_IDLE;
                else                        tx_stop_d  = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_phase_q <= '0;
      tx_bit_q   <= '0;
      tx_stop_q  <= 1'b0;
      tx_armed_q <= 1'b0;
      tx_shift_q <= '0;
      tx_txd_q   <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_phase_q <= tx_phase_d;
      tx_bit_q   <= tx_bit_d;
      tx_stop_q  <= tx_stop_d;
      tx_armed_q <= tx_armed_d;
      tx_shift_q <= tx_shift_d;
      tx_txd_q   <= tx_txd_d;
    end
  end

  assign uart_txd = tx_txd_q;
  assign tx_busy  = (tx_state_q != TX_IDLE);

endmodule

// File: tb/tb_uart_cfg.sv
// Bench for uart_cfg: an 8N1 instance (A) and a 7E2 instance (B), one bit = 16 clk.
// Expected frames and received bytes come from a bit-level frame model built from the format rules.
module tb_uart_cfg;

  localparam int F_HZ = 1843200;
  localparam int BAUD = 115200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT A: 8N1 ----------------
  logic       a_drv, a_loop, a_rxd, a_txd, a_avail, a_err, a_perr, a_ovr, a_brk, a_ack, a_wr, a_busy;
  logic [7:0] a_rdata, a_tdata;
  assign a_rxd = a_loop ? a_txd : a_drv;

  uart_cfg #(.freq_hz(F_HZ), .baud(BAUD), .data_bits(8), .parity(0), .stop_bits(1)) dut_a (
    .clk(clk), .reset(reset), .uart_rxd(a_rxd), .uart_txd(a_txd),
    .rx_data(a_rdata), .rx_avail(a_avail), .rx_error(a_err), .rx_parity_err(a_perr),
    .rx_overrun(a_ovr), .rx_break(a_brk), .rx_ack(a_ack),
    .tx_data(a_tdata), .tx_wr(a_wr), .tx_busy(a_busy)
  );

  // ---------------- DUT B: 7 data, even parity, 2 stop ----------------
  logic       b_drv, b_loop, b_rxd, b_txd, b_avail, b_err, b_perr, b_ovr, b_brk, b_ack, b_wr, b_busy;
  logic [7:0] b_rdata, b_tdata;
  assign b_rxd = b_loop ? b_txd : b_drv;

  uart_cfg #(.freq_hz(F_HZ), .baud(BAUD), .data_bits(7), .parity(2), .stop_bits(2)) dut_b (
    .clk(clk), .reset(reset), .uart_rxd(b_rxd), .uart_txd(b_txd),
    .rx_data(b_rdata), .rx_avail(b_avail), .rx_error(b_err), .rx_parity_err(b_perr),
    .rx_overrun(b_ovr), .rx_break(b_brk), .rx_ack(b_ack),
    .tx_data(b_tdata), .tx_wr(b_wr), .tx_busy(b_busy)
  );

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // status order: {avail, error, parity_err, overrun, break}
  function automatic logic [4:0] status(input int s);
    return (s == 0) ? {a_avail, a_err, a_perr, a_ovr, a_brk} : {b_avail, b_err, b_perr, b_ovr, b_brk};
  endfunction

  function automatic logic [7:0] rdata(input int s);
    return (s == 0) ? a_rdata : b_rdata;
  endfunction

  // ---------------- reference frame model ----------------
  function automatic int build_frame(input logic [7:0] b, input int dbits, input int par, input int stops,
                                     input logic flip_par, input logic stop_low, output logic [11:0] bits);
    int n = 0;
    int ones;
    logic [7:0] m;
    bits = '1;
    m    = b & 8'((1 << dbits) - 1);
    ones = $countones(m);
    bits[n] = 1'b0; n++;
    for (int i = 0; i < dbits; i++) begin bits[n] = m[i]; n++; end
    if (par != 0) begin
      bits[n] = ((par == 1) ? (ones % 2 == 0) : (ones % 2 == 1)) ^ flip_par;
      n++;
    end
    for (int i = 0; i < stops; i++) begin bits[n] = !stop_low; n++; end
    return n;
  endfunction

  // ---------------- driver tasks (all called at a negedge) ----------------
  task automatic set_line(input int s, input logic v);
    if (s == 0) a_drv = v; else b_drv = v;
  endtask

  task automatic set_ack(input int s, input logic v);
    if (s == 0) a_ack = v; else b_ack = v;
  endtask

  task automatic set_wr(input int s, input logic [7:0] d, input logic w);
    if (s == 0) begin a_tdata = d; a_wr = w; end
    else begin b_tdata = d; b_wr = w; end
  endtask

  task automatic ack(input int s);
    set_ack(s, 1'b1);
    @(negedge clk);
    set_ack(s, 1'b0);
  endtask

  // Drive a frame on the RX pin per clk; optional ack pulse and one-clk inversion at given offsets.
  task automatic drive_frame(input int s, input logic [11:0] bits, input int n, input int ack_at, input int glitch_at);
    for (int c = 0; c < n * 16; c++) begin
      set_line(s, bits[c / 16] ^ (c == glitch_at));
      set_ack(s, c == ack_at);
      @(negedge clk);
    end
    set_line(s, 1'b1);
    set_ack(s, 1'b0);
  endtask

  task automatic send_rx(input int s, input logic [7:0] b, input int ack_at, input int glitch_at);
    logic [11:0] bits;
    int n;
    n = (s == 0) ? build_frame(b, 8, 0, 1, 1'b0, 1'b0, bits) : build_frame(b, 7, 2, 2, 1'b0, 1'b0, bits);
    drive_frame(s, bits, n, ack_at, glitch_at);
    repeat (4) @(negedge clk);
  endtask

  // Write one byte, record the TX line per clk until tx_busy drops, compare against the model frame.
  task automatic tx_check(input int s, input logic [7:0] b, input int dbits, input int par, input int stops,
                          input logic poke);
    logic [11:0] bits;
    logic        line[400];
    int n, k, st, busy_n, errs;
    n = build_frame(b, dbits, par, stops, 1'b0, 1'b0, bits);
    set_wr(s, b, 1'b1);
    @(negedge clk);
    set_wr(s, b, 1'b0);
    k = 0;
    busy_n = 0;
    while (k < 400 && ((s == 0) ? a_busy : b_busy)) begin
      line[k] = (s == 0) ? a_txd : b_txd;
      busy_n++;
      set_wr(s, (poke && k == 40) ? ~b : b, poke && k == 40);
      k++;
      @(negedge clk);
    end
    set_wr(s, b, 1'b0);
    chk("tx_busy_len", busy_n, 16 * n + 1);
    st = -1;
    for (int i = 0; i < k; i++) if (st < 0 && line[i] == 1'b0) st = i;
    chk("tx_start_ofs", st, 1);
    if (st >= 0) begin
      for (int i = 0; i < n; i++) begin
        errs = 0;
        for (int m = 0; m < 16; m++)
          if (st + 16 * i + m >= k || line[st + 16 * i + m] !== bits[i]) errs++;
        chk($sformatf("tx_bit%0d_byte%02h", i, b), errs, 0);
      end
    end
  endtask

  // ---------------- table of RX vectors for B ----------------
  typedef struct {
    logic [7:0] tx;
    logic       flip;
    logic       stop_low;
    logic [7:0] exp_data;
    logic [4:0] exp_st;
  } vec_t;
  vec_t vecs[6];

  initial begin
    logic [11:0] bits;
    int          n;
    logic [7:0]  b;

    vecs[0] = '{8'h53, 1'b1, 1'b0, 8'h53, 5'b10100};
    vecs[1] = '{8'h3C, 1'b0, 1'b1, 8'h53, 5'b01000};
    vecs[2] = '{8'h00, 1'b0, 1'b1, 8'h53, 5'b01001};
    vecs[3] = '{8'hFF, 1'b0, 1'b0, 8'h7F, 5'b10000};
    vecs[4] = '{8'h2A, 1'b1, 1'b0, 8'h2A, 5'b10100};
    vecs[5] = '{8'h00, 1'b0, 1'b0, 8'h00, 5'b10000};

    reset = 1'b1;
    a_drv = 1'b1; a_loop = 1'b0; a_ack = 1'b0; a_wr = 1'b0; a_tdata = '0;
    b_drv = 1'b1; b_loop = 1'b0; b_ack = 1'b0; b_wr = 1'b0; b_tdata = '0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("reset_txd", (s == 0) ? a_txd : b_txd, 1);
      chk("reset_busy", (s == 0) ? a_busy : b_busy, 0);
      chk("reset_rx_data", rdata(s), 0);
      chk("reset_status", status(s), 0);
    end
    reset = 1'b0;
    @(negedge clk);

    // 8N1 loopback of 0xA5 (also tries a write while busy)
    a_loop = 1'b1;
    exp_q.push_back(8'hA5);
    tx_check(0, 8'hA5, 8, 0, 1, 1'b1);
    repeat (2) @(negedge clk);
    chk("a5_rx_data", rdata(0), exp_q.pop_front());
    chk("a5_status", status(0), 5'b10000);

    // 7E2 loopback of 0x53
    b_loop = 1'b1;
    exp_q.push_back(8'h53);
    tx_check(1, 8'h53, 7, 2, 2, 1'b0);
    repeat (2) @(negedge clk);
    chk("53_rx_data", rdata(1), exp_q.pop_front());
    chk("53_status", status(1), 5'b10000);

    // table-driven RX vectors on B
    b_loop = 1'b0;
    foreach (vecs[i]) begin
      ack(1);
      n = build_frame(vecs[i].tx, 7, 2, 2, vecs[i].flip, vecs[i].stop_low, bits);
      drive_frame(1, bits, n, -1, -1);
      repeat (4) @(negedge clk);
      chk($sformatf("vec%0d_rx_data", i), rdata(1), vecs[i].exp_data);
      chk($sformatf("vec%0d_status", i), status(1), vecs[i].exp_st);
    end

    // break: line low for 20 bit times, then recovery
    a_loop = 1'b0;
    ack(0);
    a_drv = 1'b0;
    repeat (320) @(negedge clk);
    chk("break_status", status(0), 5'b01001);
    chk("break_rx_data", rdata(0), 8'hA5);
    a_drv = 1'b1;
    repeat (20) @(negedge clk);
    chk("break_idle_status", status(0), 5'b01001);
    ack(0);
    chk("break_ack_status", status(0), 5'b00000);
    send_rx(0, 8'h55, -1, -1);
    chk("after_break_data", rdata(0), 8'h55);
    chk("after_break_status", status(0), 5'b10000);

    // overrun, ack, ack coincident with completion
    ack(0);
    send_rx(0, 8'h11, -1, -1);
    send_rx(0, 8'h22, -1, -1);
    chk("overrun_data", rdata(0), 8'h22);
    chk("overrun_status", status(0), 5'b10010);
    ack(0);
    chk("ack_clears", status(0), 5'b00000);
    send_rx(0, 8'h33, -1, -1);
    send_rx(0, 8'h44, 156, -1);
    chk("ack_coincident_avail", a_avail, 1);
    chk("ack_coincident_data", rdata(0), 8'h44);

    // glitch rejection
    ack(0);
    a_drv = 1'b0;
    repeat (3) @(negedge clk);
    a_drv = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_idle_status", status(0), 5'b00000);
    send_rx(0, 8'hC3, -1, 16 * 3 + 9);
    chk("glitch_bit_data", rdata(0), 8'hC3);
    chk("glitch_bit_status", status(0), 5'b10000);

    // randomized loopback on both formats
    a_loop = 1'b1;
    b_loop = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ack(0);
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      tx_check(0, b, 8, 0, 1, 1'b0);
      repeat (2) @(negedge clk);
      chk("rand_a_data", rdata(0), exp_q.pop_front());
      chk("rand_a_status", status(0), 5'b10000);
    end
    for (int i = 0; i < 4; i++) begin
      ack(1);
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b & 8'h7F);
      tx_check(1, b, 7, 2, 2, 1'b0);
      repeat (2) @(negedge clk);
      chk("rand_b_data", rdata(1), exp_q.pop_front());
      chk("rand_b_status", status(1), 5'b10000);
    end

    // reset in the middle of a 0x00 transmission
    set_wr(0, 8'h00, 1'b1);
    @(negedge clk);
    set_wr(0, 8'h00, 1'b0);
    repeat (72) @(negedge clk);
    chk("pre_reset_txd", a_txd, 0);
    reset = 1'b1;
    #1;
    chk("midreset_txd", a_txd, 1);
    chk("midreset_busy", a_busy, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    exp_q.push_back(8'h81);
    tx_check(0, 8'h81, 8, 0, 1, 1'b0);
    repeat (2) @(negedge clk);
    chk("post_reset_data", rdata(0), exp_q.pop_front());
    chk("post_reset_status", status(0), 5'b10000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
